// File: rtl/var_delay_phase_ctrl_if.sv
// Control/config bundle for var_delay_phase_ctrl: the master side drives
// mode and configuration writes, the slave side returns phase and code state.
interface var_delay_phase_ctrl_if #(
  parameter int NCH     = 4,
  parameter int CODE_W  = 4,
  parameter int DWELL_W = 8,
  parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
);
  logic                    enable;
  logic                    mode;
  logic [DWELL_W-1:0]      dwell;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [1:0]              cfg_phase;
  logic [CODE_W-1:0]       cfg_code;
  logic                    cfg_err;
  logic [1:0]              delay_sel;
  logic [NCH*CODE_W-1:0]   code_out;
  logic                    upd;
  logic                    pending;

  modport master (
    output enable, mode, dwell, cfg_we, cfg_ch, cfg_phase, cfg_code,
    input  cfg_err, delay_sel, code_out, upd, pending
  );

  modport slave (
    input  enable, mode, dwell, cfg_we, cfg_ch, cfg_phase, cfg_code,
    output cfg_err, delay_sel, code_out, upd, pending
  );
endinterface

// File: rtl/var_delay_phase_ctrl.sv
// Multi-channel delay-code sequencer: steps lead/origin/lag codes with a
// programmable dwell and commits shadowed config writes only at phase boundaries.
module var_delay_phase_ctrl #(
  parameter int NCH     = 4,
  parameter int CODE_W  = 4,
  parameter int DWELL_W = 8,
  parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  var_delay_phase_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LEAD, ORGA, LAG, ORGB} state_t;

  state_t                state_q, state_d;
  logic [DWELL_W-1:0]    cnt_q, cnt_d;
  logic                  boundary, entering, wr_ok, wr_bad, commit;
  logic [1:0]            sel_d, delay_sel_q;
  logic [CODE_W-1:0]     shadow_q [3][NCH];
  logic [CODE_W-1:0]     active_q [3][NCH];
  logic [CODE_W-1:0]     active_d [3][NCH];
  logic [NCH*CODE_W-1:0] code_out_d, code_out_q;
  logic                  pending_q, upd_q, cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.mode) state_d = LEAD;
        default: begin
          if (cnt_q == '0) begin
            boundary = 1'b1;
            if (!bus.mode) begin
              state_d = IDLE;
            end else begin
              case (state_q)
                LEAD:    state_d = ORGA;
                ORGA:    state_d = LAG;
                LAG:     state_d = ORGB;
                default: state_d = LEAD;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_ok    = bus.cfg_we && (bus.cfg_phase != 2'd3) && (int'(bus.cfg_ch) < NCH);
    wr_bad   = bus.cfg_we && !wr_ok;
    entering = (state_d != IDLE) && ((state_q == IDLE) || boundary);
    commit   = pending_q && ((state_q == IDLE) || boundary);

    if (state_d == IDLE) cnt_d = '0;
    else if (entering)   cnt_d = bus.dwell;
    else                 cnt_d = cnt_q - DWELL_W'(1);

    case (state_d)
      LEAD:    sel_d = 2'd0;
      LAG:     sel_d = 2'd2;
      default: sel_d = 2'd1;
    endcase

    // Code output is registered from the post-commit bank so it moves on the same edge as the state.
    active_d = active_q;
    if (commit) active_d = shadow_q;

    code_out_d = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      code_out_d[ch*CODE_W +: CODE_W] = active_d[sel_d][ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      delay_sel_q <= 2'd1;
      code_out_q  <= '0;
      pending_q   <= 1'b0;
      upd_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int unsigned p = 0; p < 3; p++) begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
          shadow_q[p][ch] <= '0;
          active_q[p][ch] <= '0;
        end
      end
    end else begin
      cnt_q       <= cnt_d;
      delay_sel_q <= sel_d;
      code_out_q  <= code_out_d;
      active_q    <= active_d;
      // Active copies the old shadow, so a write on a commit edge stays pending.
      if (wr_ok) shadow_q[bus.cfg_phase][bus.cfg_ch] <= bus.cfg_code;
      pending_q   <= wr_ok || (pending_q && !commit);
      upd_q       <= commit;
      cfg_err_q   <= wr_bad;
    end
  end

  assign bus.delay_sel = delay_sel_q;
  assign bus.code_out  = code_out_q;
  assign bus.pending   = pending_q;
  assign bus.upd       = upd_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_var_delay_phase_ctrl.sv
// Bench for var_delay_phase_ctrl: directed scenarios plus random traffic, all
// compared every cycle against a phase-sequence reference model.
module tb_var_delay_phase_ctrl;
  localparam int NCH     = 3;
  localparam int CODE_W  = 4;
  localparam int DWELL_W = 8;
  localparam int CH_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  var_delay_phase_ctrl_if #(.NCH(NCH), .CODE_W(CODE_W), .DWELL_W(DWELL_W), .CH_W(CH_W)) bus ();

  var_delay_phase_ctrl #(.NCH(NCH), .CODE_W(CODE_W), .DWELL_W(DWELL_W), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase index -1 = idle, 0..3 = lead, origin A, lag, origin B.
  int m_phase, m_elapsed, m_len;
  int m_shadow [3][NCH];
  int m_active [3][NCH];
  bit m_pending, m_upd, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_sel();
    case (m_phase)
      0:       return 0;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic model_edge();
    bit ok, boundary, commit;
    int nxt;
    if (rst) begin
      m_phase = -1; m_elapsed = 0; m_len = 1;
      for (int p = 0; p < 3; p++)
        for (int c = 0; c < NCH; c++) begin
          m_shadow[p][c] = 0;
          m_active[p][c] = 0;
        end
      m_pending = 0; m_upd = 0; m_err = 0;
      return;
    end
    ok       = bus.cfg_we && (bus.cfg_phase != 2'd3) && (int'(bus.cfg_ch) < NCH);
    boundary = (m_phase >= 0) && (m_elapsed == m_len - 1);
    commit   = m_pending && ((m_phase < 0) || (bus.enable && boundary));
    if (!bus.enable)    nxt = -1;
    else if (m_phase < 0) nxt = bus.mode ? 0 : -1;
    else if (boundary)  nxt = bus.mode ? (m_phase + 1) % 4 : -1;
    else                nxt = m_phase;
    if (nxt >= 0 && (m_phase < 0 || boundary)) begin
      m_len = int'(bus.dwell) + 1;
      m_elapsed = 0;
    end else begin
      m_elapsed++;
    end
    m_phase = nxt;
    if (commit) m_active = m_shadow;
    if (ok) m_shadow[bus.cfg_phase][bus.cfg_ch] = int'(bus.cfg_code);
    m_pending = ok || (m_pending && !commit);
    m_upd = commit;
    m_err = bus.cfg_we && !ok;
  endtask

  task automatic step();
    logic [NCH*CODE_W-1:0] exp_code;
    int s;
    @(posedge clk);
    model_edge();
    #1;
    s = m_sel();
    for (int c = 0; c < NCH; c++) exp_code[c*CODE_W +: CODE_W] = CODE_W'(m_active[s][c]);
    check("delay_sel", bus.delay_sel, s);
    check("code_out", bus.code_out, exp_code);
    check("upd", bus.upd, m_upd);
    check("pending", bus.pending, m_pending);
    check("cfg_err", bus.cfg_err, m_err);
  endtask

  task automatic wr(input int ch, input int ph, input int code);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_phase = 2'(ph);
    bus.cfg_code  = CODE_W'(code);
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic wait_sel(input logic [1:0] sel);
    int n = 0;
    while (bus.delay_sel != sel && n < 3000) begin
      step();
      n++;
    end
    check("wait_sel", bus.delay_sel, sel);
  endtask

  task automatic run_len(input logic [1:0] sel, output int n);
    n = 0;
    while (bus.delay_sel == sel && n < 2000) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int sel_pat [12]  = '{0,0,0,1,1,1,2,2,2,1,1,1};
    int code_pat [12] = '{3,3,3,7,7,7,11,11,11,7,7,7};

    bus.enable = 1'b0; bus.mode = 1'b0; bus.dwell = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_phase = '0; bus.cfg_code = '0;

    // reset, then IDLE write of ch1 origin
    rst = 1'b1;
    step(); step();
    check("rst_sel", bus.delay_sel, 1);
    check("rst_code", bus.code_out, 0);
    rst = 1'b0;
    wr(1, 1, 4'hA);
    check("idle_pending", bus.pending, 1);
    step();
    check("idle_upd", bus.upd, 1);
    check("idle_ch1_orig", bus.code_out[7:4], 4'hA);
    check("idle_pend_clr", bus.pending, 0);

    // dither sequence, dwell=2
    wr(0, 0, 3); wr(0, 1, 7); wr(0, 2, 11);
    step(); step();
    bus.dwell = 8'd2; bus.enable = 1'b1; bus.mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      check("dith_sel", bus.delay_sel, sel_pat[i % 12]);
      check("dith_code", bus.code_out[3:0], code_pat[i % 12]);
    end

    // shadowed write during LEAD
    bus.enable = 1'b0; step();
    bus.dwell = 8'd5; bus.enable = 1'b1;
    step();
    wr(0, 0, 1);
    check("shadow_hold", bus.code_out[3:0], 3);
    n = 0;
    while (bus.delay_sel == 0 && n < 20) begin step(); n++; end
    check("orga_upd", bus.upd, 1);
    check("orga_sel", bus.delay_sel, 1);
    wait_sel(0);
    check("lead_new_code", bus.code_out[3:0], 1);

    // rejected writes
    bus.enable = 1'b0; step(); step();
    wr(0, 3, 5);
    check("err_phase3", bus.cfg_err, 1);
    check("err_phase3_pend", bus.pending, 0);
    step();
    check("err_gap", bus.cfg_err, 0);
    wr(NCH, 1, 5);
    check("err_ch", bus.cfg_err, 1);
    check("err_ch_pend", bus.pending, 0);
    step();

    // mode drop mid-LAG completes the phase, then IDLE
    bus.dwell = 8'd3; bus.enable = 1'b1; bus.mode = 1'b1;
    wait_sel(2);
    step();
    bus.mode = 1'b0;
    run_len(2, n);
    check("lag_rest_len", n, 3);
    for (int i = 0; i < 6; i++) begin
      step();
      check("idle_hold", bus.delay_sel, 1);
    end

    // enable drop mid-LEAD
    bus.mode = 1'b1;
    step();
    check("lead_entry", bus.delay_sel, 0);
    step();
    bus.enable = 1'b0;
    step();
    check("en_drop", bus.delay_sel, 1);
    step();

    // reset mid-ORGB with a pending write
    bus.dwell = 8'd2; bus.enable = 1'b1; bus.mode = 1'b1;
    wait_sel(2);
    wait_sel(1);
    wr(2, 0, 9);
    rst = 1'b1;
    step();
    check("rst_mid_sel", bus.delay_sel, 1);
    check("rst_mid_code", bus.code_out, 0);
    check("rst_mid_pend", bus.pending, 0);
    rst = 1'b0;
    bus.enable = 1'b0;
    step();

    // maximum dwell: each phase exactly 256 cycles
    bus.dwell = 8'd255; bus.enable = 1'b1; bus.mode = 1'b1;
    step();
    run_len(0, n); check("len_lead", n, 256);
    run_len(1, n); check("len_orga", n, 256);
    run_len(2, n); check("len_lag", n, 256);
    run_len(1, n); check("len_orgb", n, 256);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.enable    = ($urandom_range(0, 15) != 0);
      bus.mode      = ($urandom_range(0, 7) != 0);
      bus.dwell     = 8'($urandom_range(0, 3));
      bus.cfg_we    = ($urandom_range(0, 3) == 0);
      bus.cfg_ch    = CH_W'($urandom_range(0, 3));
      bus.cfg_phase = 2'($urandom_range(0, 3));
      bus.cfg_code  = CODE_W'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
